playfield_scroll_writer: RTL and testbench
==========================================

Name: playfield_scroll_writer

Overview:
- Writer side of the playfield bitmap. Owns a 28x32 register-file maze.
- Answers the video scanner's per-pixel playfield lookups with a registered result.
- Fills the maze from two sources: CPU/game-logic row writes over a valid/ready port, and an automatic per-frame scroll engine that shifts rows down and inserts LFSR-generated obstacle rows at the top.

Parameters:
- X_ORG, 304, hpos of maze column 0.
- Y_ORG, 224, vpos of maze row 0.
- SCROLL_DIV, 4, frame_ticks per scroll step (1..255).
- LFSR_SEED, 32'hACE1_1234, reset value of the obstacle LFSR. Must be non-zero.
- DENSITY, 2, number of AND-ed random terms per obstacle bit (1 or 2).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- hpos, input, 9, scanner horizontal position.
- vpos, input, 9, scanner vertical position.
- playfield_gfx, output, 1, maze bit at (hpos,vpos); registered.
- frame_tick, input, 1, one-cycle pulse per frame (vsync start).
- scroll_en, input, 1, enables the frame divider / scrolling.
- wr_valid, input, 1, row-write request.
- wr_ready, output, 1, row write accepted when valid&ready.
- wr_row, input, 5, target row 0..31.
- wr_data, input, 32, row bits; bit 31 = column 0 (leftmost).
- busy, output, 1, scroll engine active.
- scroll_count, output, 16, number of completed scroll steps; wraps.

Behaviour:
- Reset (async, rst_n=0):
  - row0 = row27 = 32'hFFFF_FFFF; rows 1..26 = 32'h8000_0001.
  - playfield_gfx=0, busy=0, scroll_count=0, divider=0, pending=0, LFSR=LFSR_SEED, FSM=IDLE.
  - wr_ready=0 during reset; 1 from the first cycle after reset deasserts.
- Read path:
  - x = hpos - X_ORG, y = vpos - Y_ORG, 10-bit unsigned.
  - If x<32 and y<28: playfield_gfx <= row[y][31-x]; else playfield_gfx <= 0.
  - Latency is exactly 1 clk.
  - Reads reflect the array state before that cycle's write.
- Write port:
  - wr_ready = (state==IDLE) & ~start_scroll.
  - Accepted write to rows 1..26 stores {1'b1, wr_data[30:1], 1'b1}; border columns are forced to 1.
  - Writes to rows 0, 27, or 28..31 are accepted (handshake completes) and discarded.
- Frame divider:
  - On frame_tick & scroll_en: if divider==SCROLL_DIV-1, then divider<=0 and pending<=1; else divider++.
  - scroll_en=0 holds the divider; pending is not cleared.
  - start_scroll = pending & (state==IDLE) & ~(wr_valid&wr_ready_prev-cycle irrelevant). Rule: in IDLE, an accepted write has priority only if pending was 0 at the start of the cycle; otherwise the scroll starts and wr_ready=0.
- FSM:
  - IDLE:
    - if start_scroll: pending<=0, ptr<=26, busy<=1, go to SHIFT.
  - SHIFT:
    - row[ptr] <= row[ptr-1]; ptr--.
    - When ptr==2 (last copy, row2<=row1), go to INSERT. This is 25 cycles.
  - INSERT:
    - Step the LFSR once (Galois, polynomial x^32+x^22+x^2+x+1, mask 32'h8020_0003).
    - r = next LFSR; for DENSITY=2, r = r & {r[15:0], r[31:16]}.
    - row1 <= {1'b1, r[30:1], 1'b1}.
    - scroll_count++, busy<=0, go to IDLE.
  - busy is high for exactly 26 cycles per scroll.
- Boundaries:
  - frame_tick while busy: the divider still counts; a resulting request sets pending and is serviced on return to IDLE.
  - A second request while pending=1 is merged (not queued).
  - Reset mid-scroll: full array reinit; no partial state survives.
  - Rows 0/27 are never modified.

Optional Feature:
- PF_COLLIDE_EN.
- Defined: adds ports player_gfx (in, 1), collision (out, 1), collision_clr (in, 1).
  - Sticky flag set when player_gfx & playfield_gfx (same cycle; player_gfx is aligned to the registered output).
  - Cleared by collision_clr; clear wins over a simultaneous set.
  - Reset value 0.
- Undefined: the ports and logic are absent.

Decomposition:
- Shared package pf_pkg:
  - PF_ROWS=28, PF_COLS=32, PF_BORDER_ROW=32'hFFFF_FFFF, PF_EMPTY_ROW=32'h8000_0001.
  - FSM state enum {IDLE, SHIFT, INSERT}.
  - LFSR mask constant.
- One natural sub-module: pf_lfsr32 (enable-stepped Galois LFSR with seed parameter), reusable for enemy spawning.

Test Plan:
- Reset release → the cycle after (hpos=304,vpos=224) gives gfx=1; (305,225)→0; (335,225)→1; (336,225)→0; busy=0; wr_ready=1.
- Write wr_row=5, wr_data=32'h0000_FF00 → readback of row5 columns: x=16..23 read 1; x=0 and x=31 read 1; row stored = 32'h8000_FF01.
- SCROLL_DIV=4, scroll_en=1, 4 frame_ticks → busy high 26 cycles; old row5 appears at row6; row1 border bits=1; scroll_count=1; rows 0/27 still all ones.
- wr_valid held during busy → wr_ready=0 for all 26 busy cycles; the write completes the first IDLE cycle after; the data lands post-scroll.
- pending=1 and wr_valid in the same IDLE cycle → scroll starts, write stalls 26 cycles. Write to row 27 with 0 → accepted, row27 unchanged.
- rst_n pulsed low at SHIFT ptr=15 → immediately busy=0, all rows at reset pattern, scroll_count=0; with PF_COLLIDE_EN, player_gfx=1 at the border pixel → collision=1 until collision_clr.

Source files
------------

// File: rtl/pf_pkg.sv
// Shared constants, state encoding and row helper for the playfield writer.
package pf_pkg;

  localparam int unsigned PF_ROWS       = 28;
  localparam int unsigned PF_COLS       = 32;
  localparam logic [31:0] PF_BORDER_ROW = 32'hFFFF_FFFF;
  localparam logic [31:0] PF_EMPTY_ROW  = 32'h8000_0001;
  // Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] PF_LFSR_MASK  = 32'h8020_0003;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StInsert
  } pf_state_e;

  // Interior rows always keep both side walls solid.
  function automatic logic [31:0] pf_frame_row(input logic [31:0] d);
    return {1'b1, d[30:1], 1'b1};
  endfunction

endpackage

// File: rtl/pf_lfsr32.sv
// Enable-stepped 32-bit Galois LFSR with a configurable non-zero seed.
module pf_lfsr32
  import pf_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_1234
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] value
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ PF_LFSR_MASK) : (lfsr_q >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (en) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/playfield_scroll_writer.sv
// Playfield maze writer: registered pixel lookup, CPU row writes and a per-frame scroll engine.
// Define PF_COLLIDE_EN to add the sticky player/playfield collision flag.
module playfield_scroll_writer
  import pf_pkg::*;
#(
  parameter int unsigned X_ORG      = 304,
  parameter int unsigned Y_ORG      = 224,
  parameter int unsigned SCROLL_DIV = 4,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_1234,
  parameter int unsigned DENSITY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  hpos,
  input  logic [8:0]  vpos,
  output logic        playfield_gfx,
`ifdef PF_COLLIDE_EN
  input  logic        player_gfx,
  input  logic        collision_clr,
  output logic        collision,
`endif
  input  logic        frame_tick,
  input  logic        scroll_en,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_row,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic [15:0] scroll_count
);

  pf_state_e   state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [7:0]  div_q;
  logic        pending_q;
  logic        init_q;
  logic [15:0] count_q;
  logic        gfx_q;
  logic [31:0] rows_q [PF_ROWS];

  logic        start_scroll;
  logic        wr_fire;
  logic        div_wrap;
  logic        lfsr_en;
  logic [31:0] lfsr_value;
  logic [31:0] obstacle;
  logic [9:0]  x_off, y_off;

  // The LFSR steps on the last shift cycle so its value is ready for the insert.
  pf_lfsr32 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lfsr_en),
    .value (lfsr_value)
  );

  always_comb begin
    obstacle = lfsr_value;
    if (DENSITY == 2) begin
      obstacle = lfsr_value & {lfsr_value[15:0], lfsr_value[31:16]};
    end
  end

  // A pending scroll beats a write presented in the same idle cycle.
  assign start_scroll = pending_q & (state_q == StIdle);
  assign wr_ready     = init_q & (state_q == StIdle) & ~pending_q;
  assign wr_fire      = wr_valid & wr_ready;
  assign div_wrap     = frame_tick & scroll_en & (div_q == 8'(SCROLL_DIV - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lfsr_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_scroll) begin
          ptr_d   = 5'd26;
          state_d = StShift;
        end
      end
      StShift: begin
        ptr_d = ptr_q - 5'd1;
        if (ptr_q == 5'd2) begin
          lfsr_en = 1'b1;
          state_d = StInsert;
        end
      end
      StInsert: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= 5'd0;
      div_q     <= 8'd0;
      pending_q <= 1'b0;
      init_q    <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      init_q  <= 1'b1;
      if (frame_tick && scroll_en) begin
        div_q <= div_wrap ? 8'd0 : div_q + 8'd1;
      end
      if (div_wrap) begin
        pending_q <= 1'b1;
      end else if (start_scroll) begin
        pending_q <= 1'b0;
      end
      if (state_q == StInsert) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PF_ROWS; i++) begin
        rows_q[i] <= ((i == 0) || (i == PF_ROWS - 1)) ? PF_BORDER_ROW : PF_EMPTY_ROW;
      end
    end else begin
      if (state_q == StShift) begin
        rows_q[ptr_q] <= rows_q[ptr_q - 5'd1];
      end else if (state_q == StInsert) begin
        rows_q[1] <= pf_frame_row(obstacle);
      end else if (wr_fire && (wr_row >= 5'd1) && (wr_row <= 5'd26)) begin
        rows_q[wr_row] <= pf_frame_row(wr_data);
      end
    end
  end

  assign x_off = {1'b0, hpos} - 10'(X_ORG);
  assign y_off = {1'b0, vpos} - 10'(Y_ORG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gfx_q <= 1'b0;
    end else if ((x_off < 10'd32) && (y_off < 10'd28)) begin
      gfx_q <= rows_q[y_off[4:0]][5'd31 - x_off[4:0]];
    end else begin
      gfx_q <= 1'b0;
    end
  end

`ifdef PF_COLLIDE_EN
  logic collision_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_q <= 1'b0;
    end else if (collision_clr) begin
      collision_q <= 1'b0;
    end else if (player_gfx && gfx_q) begin
      collision_q <= 1'b1;
    end
  end

  assign collision = collision_q;
`endif

  assign playfield_gfx = gfx_q;
  assign busy          = (state_q != StIdle);
  assign scroll_count  = count_q;

endmodule

// File: tb/tb_playfield_scroll_writer.sv
// Directed bench for playfield_scroll_writer with a behavioural maze model and pixel scoreboard.
module tb_playfield_scroll_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  hpos = '0;
  logic [8:0]  vpos = '0;
  logic        playfield_gfx;
  logic        frame_tick = 1'b0;
  logic        scroll_en = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_row = '0;
  logic [31:0] wr_data = '0;
  logic        busy;
  logic [15:0] scroll_count;
`ifdef PF_COLLIDE_EN
  logic        player_gfx = 1'b0;
  logic        collision_clr = 1'b0;
  logic        collision;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_rows [28];
  logic [31:0] m_lfsr;
  logic        exp_q [$];

  playfield_scroll_writer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hpos          (hpos),
    .vpos          (vpos),
    .playfield_gfx (playfield_gfx),
`ifdef PF_COLLIDE_EN
    .player_gfx    (player_gfx),
    .collision_clr (collision_clr),
    .collision     (collision),
`endif
    .frame_tick    (frame_tick),
    .scroll_en     (scroll_en),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_row        (wr_row),
    .wr_data       (wr_data),
    .busy          (busy),
    .scroll_count  (scroll_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 28; r++) begin
      m_rows[r] = ((r == 0) || (r == 27)) ? 32'hFFFF_FFFF : 32'h8000_0001;
    end
    m_lfsr = 32'hACE1_1234;
  endtask

  task automatic model_scroll();
    logic [31:0] r;
    for (int i = 26; i >= 2; i--) m_rows[i] = m_rows[i-1];
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
    r = m_lfsr & {m_lfsr[15:0], m_lfsr[31:16]};
    m_rows[1] = {1'b1, r[30:1], 1'b1};
  endtask

  function automatic logic model_px(input int h, input int v);
    int x;
    int y;
    x = h - 304;
    y = v - 224;
    if ((x >= 0) && (x < 32) && (y >= 0) && (y < 28)) return m_rows[y][31-x];
    return 1'b0;
  endfunction

  task automatic check_px(input int h, input int v);
    exp_q.push_back(model_px(h, v));
    hpos = 9'(h);
    vpos = 9'(v);
    tick();
    chk($sformatf("px_%0d_%0d", h, v), 32'(playfield_gfx), 32'(exp_q.pop_front()));
  endtask

  task automatic check_row(input int r);
    for (int x = 0; x < 32; x++) check_px(304 + x, 224 + r);
  endtask

  task automatic do_write(input int row, input logic [31:0] data);
    int g = 0;
    wr_row   = 5'(row);
    wr_data  = data;
    wr_valid = 1'b1;
    while (!wr_ready && g < 100) begin
      tick();
      g++;
    end
    chk($sformatf("wr_accept_row%0d", row), 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    if ((row >= 1) && (row <= 26)) m_rows[row] = {1'b1, data[30:1], 1'b1};
  endtask

  task automatic pulse_frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
  endtask

  // Counts busy cycles from now until busy drops (bounded).
  task automatic wait_scroll(output int len);
    int g = 0;
    len = 0;
    while (!busy && g < 200) begin
      tick();
      g++;
    end
    while (busy && g < 200) begin
      len++;
      tick();
      g++;
    end
  endtask

  initial begin
    int stall;
    int busy_len;
    int len;
    int g;

    model_reset();
    repeat (3) tick();
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(scroll_count), 32'd0);
    chk("rst_gfx", 32'(playfield_gfx), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    check_px(304, 224);
    check_px(305, 225);
    check_px(335, 225);
    check_px(336, 225);
    check_px(303, 224);
    check_px(304, 251);
    check_px(304, 252);

    do_write(5, 32'h0000_FF00);
    check_row(5);

    // Scroll 1: write presented in the same idle cycle as the pending request
    scroll_en = 1'b1;
    repeat (3) pulse_frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    wr_row   = 5'd10;
    wr_data  = 32'h1234_5678;
    wr_valid = 1'b1;
    chk("pend_wr_ready", 32'(wr_ready), 32'd0);
    chk("pend_busy", 32'(busy), 32'd0);
    stall = 0;
    busy_len = 0;
    g = 0;
    while (!wr_ready && g < 200) begin
      if (busy) busy_len++;
      stall++;
      tick();
      g++;
    end
    chk("s1_stall", 32'(stall), 32'd27);
    chk("s1_busy_len", 32'(busy_len), 32'd26);
    chk("s1_busy_at_accept", 32'(busy), 32'd0);
    tick();
    wr_valid = 1'b0;
    model_scroll();
    m_rows[10] = {1'b1, wr_data[30:1], 1'b1};
    chk("s1_count", 32'(scroll_count), 32'd1);
    check_row(0);
    check_row(1);
    check_row(5);
    check_row(6);
    check_row(10);
    check_row(27);

    do_write(27, 32'h0000_0000);
    check_row(27);
    do_write(0, 32'h0000_0000);
    check_row(0);

    // Scroll 2 with two requests arriving while busy: merged into one more scroll
    repeat (4) pulse_frame();
    chk("s2_busy", 32'(busy), 32'd1);
    repeat (8) pulse_frame();
    wait_scroll(len);
    chk("s2_rest", 32'(len), 32'd10);
    model_scroll();
    chk("s3_pend_ready", 32'(wr_ready), 32'd0);
    wait_scroll(len);
    chk("s3_busy_len", 32'(len), 32'd26);
    model_scroll();
    scroll_en = 1'b0;
    repeat (40) tick();
    chk("merge_idle", 32'(busy), 32'd0);
    chk("s3_count", 32'(scroll_count), 32'd3);
    check_row(1);
    check_row(2);
    check_row(3);
    check_row(27);

    // Scroll 4 interrupted by reset while ptr is 15
    scroll_en = 1'b1;
    repeat (4) pulse_frame();
    chk("s4_busy", 32'(busy), 32'd1);
    repeat (11) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", 32'(scroll_count), 32'd0);
    chk("midrst_wr_ready", 32'(wr_ready), 32'd0);
    chk("midrst_gfx", 32'(playfield_gfx), 32'd0);
    tick();
    scroll_en = 1'b0;
    rst_n = 1'b1;
    model_reset();
    tick();
    for (int r = 0; r < 28; r++) check_row(r);
    chk("post_midrst_busy", 32'(busy), 32'd0);

`ifdef PF_COLLIDE_EN
    hpos = 9'd304;
    vpos = 9'd224;
    tick();
    player_gfx = 1'b1;
    tick();
    player_gfx = 1'b0;
    chk("coll_set", 32'(collision), 32'd1);
    tick();
    chk("coll_sticky", 32'(collision), 32'd1);
    collision_clr = 1'b1;
    player_gfx = 1'b1;
    tick();
    collision_clr = 1'b0;
    player_gfx = 1'b0;
    chk("coll_clr", 32'(collision), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
